// File: rtl/mac_word_accum_pkg.sv
// Shared constants and state encoding for the IDDMM word accumulator.
package mac_word_accum_pkg;

  localparam int unsigned DefaultW      = 16;
  localparam int unsigned DefaultNWords = 256;

  // Index must reach NWORDS itself for the closing carry word.
  function automatic int unsigned idx_width(input int unsigned nwords);
    return $clog2(nwords + 1);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } state_e;

endpackage

// File: rtl/mac_word_accum.sv
// Word-serial multiply-accumulate: adds each 2W-bit partial product, an addend word and the
// running carry, emitting one W-bit word per beat plus a closing carry word per row.
module mac_word_accum
  import mac_word_accum_pkg::*;
#(
  parameter int unsigned W      = DefaultW,
  parameter int unsigned NWORDS = DefaultNWords,
  localparam int unsigned IW    = idx_width(NWORDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2*W-1:0]  in_prod_i,
  input  logic [W-1:0]    in_add_i,
  input  logic            in_first_i,
  input  logic            in_last_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [W-1:0]    out_data_o,
  output logic [IW-1:0]   out_idx_o,
  output logic            out_last_o,
  output logic            busy_o,
  output logic            err_o
);

  state_e        state_q, state_d;
  logic [W-1:0]  carry_q, carry_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic          out_last_q, out_last_d;
  logic          err_q, err_d;

  logic          out_free, accept, first_eff, last_eff, overflow;
  logic [W-1:0]  carry_in;
  logic [2*W-1:0] sum;
  logic [IW-1:0] base_idx, next_idx;

  assign out_free   = !out_valid_q || out_ready_i;
  assign in_ready_o = rst_n && (state_q != StFlush) && out_free;
  assign accept     = in_valid_i && in_ready_o;

  // A beat arriving in IDLE always starts a row, whatever in_first says.
  assign first_eff = in_first_i || (state_q == StIdle);
  assign carry_in  = first_eff ? '0 : carry_q;
  assign sum       = in_prod_i + {{W{1'b0}}, in_add_i} + {{W{1'b0}}, carry_in};
  assign base_idx  = first_eff ? '0 : cnt_q;
  assign next_idx  = base_idx + IW'(1);
  assign overflow  = !in_last_i && (next_idx == IW'(NWORDS));
  assign last_eff  = in_last_i || overflow;

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    err_d       = err_q;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle, StRun: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = sum[W-1:0];
          out_idx_d   = base_idx;
          out_last_d  = 1'b0;
          carry_d     = sum[2*W-1:W];
          cnt_d       = next_idx;
          if (state_q == StIdle) begin
            err_d = !in_first_i;
          end else if (in_first_i) begin
            err_d = 1'b1;
          end
          if (overflow) begin
            err_d = 1'b1;
          end
          state_d = last_eff ? StFlush : StRun;
        end
      end
      StFlush: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = carry_q;
          out_idx_d   = cnt_q;
          out_last_d  = 1'b1;
          carry_d     = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      carry_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_last_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != StIdle) || out_valid_q;

endmodule

// File: tb/tb_mac_word_accum.sv
// Bench for mac_word_accum: directed rows plus random 256-word rows checked against a
// wide-integer model of the whole row sum.
module tb_mac_word_accum;

  localparam int W  = 16;
  localparam int NW = 256;
  localparam int IW = 9;
  localparam int TW = 16 * (NW + 1) + 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_first, in_last;
  logic [31:0]   in_prod;
  logic [15:0]   in_add;
  logic          out_valid, out_ready, out_last, busy, err;
  logic [15:0]   out_data;
  logic [IW-1:0] out_idx;

  always #5 clk = ~clk;

  mac_word_accum #(.W(W), .NWORDS(NW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_prod_i   (in_prod),
    .in_add_i    (in_add),
    .in_first_i  (in_first),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .err_o       (err)
  );

  typedef struct packed {
    logic [15:0]   d;
    logic [IW-1:0] i;
    logic          l;
  } word_t;

  word_t       got[$];
  logic [31:0] prod_a[NW];
  logic [15:0] add_a[NW];
  int          checks = 0;
  int          errors = 0;
  bit          stall_en = 1'b0;

  // Inputs only change just after posedge, so the negedge view is what the next edge will see.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back({out_data, out_idx, out_last});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ready();
    if (stall_en) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] p, input logic [15:0] a, input bit f, input bit l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_add   = a;
    in_first = f;
    in_last  = l;
    rand_ready();
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(posedge clk); #1;
      rand_ready();
      @(negedge clk);
      guard++;
    end
    chk("beat_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (stall_en) begin
      repeat ($urandom_range(0, 1)) begin
        rand_ready();
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_row(input int n, input bit f0, input bit lastflag);
    for (int j = 0; j < n; j++) begin
      send(prod_a[j], add_a[j], (j == 0) ? f0 : 1'b0, (j == n - 1) ? lastflag : 1'b0);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 3000) begin
      @(posedge clk); #1;
      rand_ready();
      @(negedge clk);
      g++;
    end
    chk("drain_busy", busy, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic fill(input int n);
    logic [15:0] x, y;
    for (int j = 0; j < n; j++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      prod_a[j] = 32'(x) * 32'(y);
      add_a[j]  = 16'($urandom);
    end
  endtask

  // The row's words are just the base-2^16 digits of sum((prod_j + add_j) * 2^(16j)).
  function automatic logic [TW-1:0] model_total(input int n);
    logic [TW-1:0] total;
    total = '0;
    for (int j = 0; j < n; j++) begin
      total = total + ((TW'(prod_a[j]) + TW'(add_a[j])) << (16 * j));
    end
    return total;
  endfunction

  task automatic check_row(input string tag, input int n);
    logic [TW-1:0] total;
    total = model_total(n);
    chk($sformatf("%s_count", tag), got.size(), n + 1);
    for (int k = 0; k <= n; k++) begin
      if (k < got.size()) begin
        chk($sformatf("%s_data%0d", tag, k), got[k].d, total[16*k +: 16]);
        chk($sformatf("%s_idx%0d", tag, k), got[k].i, k);
        chk($sformatf("%s_last%0d", tag, k), got[k].l, (k == n));
      end
    end
    got.delete();
  endtask

  initial begin
    logic [TW-1:0] tot;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_add    = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);

    // Single-word row
    prod_a[0] = 32'hFFFE_0001;
    add_a[0]  = 16'hFFFF;
    send_row(1, 1'b1, 1'b1);
    drain();
    if (got.size() == 2) begin
      chk("tp1_word0", got[0].d, 16'h0000);
      chk("tp1_carry", got[1].d, 16'hFFFF);
    end
    check_row("tp1", 1);

    // Three-word row with fixed values
    prod_a[0] = 32'h0001_0002;
    prod_a[1] = 32'h0003_0004;
    prod_a[2] = 32'h0000_FFFF;
    for (int j = 0; j < 3; j++) add_a[j] = 16'h0;
    send_row(3, 1'b1, 1'b1);
    drain();
    if (got.size() == 4) begin
      chk("tp2_w2", got[2].d, 16'h0002);
      chk("tp2_carry", got[3].d, 16'h0001);
    end
    check_row("tp2", 3);
    chk("tp2_err", err, 0);

    // Missing in_first in IDLE: flagged, but computed as a first beat
    fill(4);
    send_row(4, 1'b0, 1'b1);
    drain();
    chk("tp4_err_set", err, 1);
    check_row("tp4", 4);
    fill(3);
    send(prod_a[0], add_a[0], 1'b1, 1'b0);
    chk("tp4_err_clear", err, 0);
    send(prod_a[1], add_a[1], 1'b0, 1'b0);
    send(prod_a[2], add_a[2], 1'b0, 1'b1);
    drain();
    check_row("tp4b", 3);

    // Backpressure for 5 cycles while word 1 sits in the output register
    fill(6);
    tot = model_total(6);
    send(prod_a[0], add_a[0], 1'b1, 1'b0);
    send(prod_a[1], add_a[1], 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_prod   = prod_a[2];
    in_add    = add_a[2];
    in_first  = 1'b0;
    in_last   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, tot[16 +: 16]);
      chk("bp_out_idx", out_idx, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int j = 2; j < 6; j++) send(prod_a[j], add_a[j], 1'b0, (j == 5));
    drain();
    check_row("bp", 6);

    // Reset in the middle of a 5-word row
    fill(5);
    for (int j = 0; j < 3; j++) send(prod_a[j], add_a[j], (j == 0), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_out_idx", out_idx, 0);
    chk("mrst_out_last", out_last, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", err, 0);
    chk("mrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got.delete();
    @(posedge clk); #1;
    fill(4);
    send_row(4, 1'b1, 1'b1);
    drain();
    check_row("post_rst", 4);

    // Random full rows with stalls, including the all-ones carry chain
    stall_en = 1'b1;
    fill(NW);
    prod_a[9]  = 32'hFFFE_0001;
    add_a[9]   = 16'hFFFF;
    prod_a[10] = 32'hFFFE_0001;
    add_a[10]  = 16'hFFFF;
    send_row(NW, 1'b1, 1'b1);
    drain();
    chk("rnd_err", err, 0);
    if (got.size() > 10) chk("rnd_max_word", got[10].d, 16'hFFFF);
    check_row("rnd", NW);

    // Row hits NWORDS without in_last: flagged and closed anyway
    fill(NW);
    send_row(NW, 1'b1, 1'b0);
    drain();
    chk("ovf_err", err, 1);
    check_row("ovf", NW);
    stall_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
